// File: rtl/usb_cmd_engine.sv
// usb_cmd_engine
//   Protocol stage behind the FT232H bridge. Pops host bytes from the receive
//   FIFO, decodes write (0x01) and read (0x02) frames, runs each frame as one
//   transaction on the internal SoC bus, and pushes response bytes into the
//   transmit FIFO. Multi-byte fields are little-endian.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_empty/rx_rd_en     receive FIFO status / pop
//   rx_dout               receive FIFO data, valid the cycle after a pop
//   tx_full/tx_wr_en      transmit FIFO status / push
//   tx_din                transmit FIFO data, valid with tx_wr_en
//   req_valid/req_ready   bus request handshake
//   req_we/req_addr/req_wdata  bus request payload, stable while req_valid
//   rsp_valid/rsp_rdata   one-cycle bus response pulse and read data
//   err_cnt               aborted-frame count, saturating at 255
//   busy                  high whenever the engine is not idle
module usb_cmd_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  input  logic [7:0]        rx_dout,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [7:0]        tx_din,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BW         = $clog2(MAX_BYTES + 1);
  localparam int TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BYTES - 1);
  // Only meaningful when TIMEOUT > 0; the compare below is gated on that.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    REQ,
    WAIT,
    RESP_HDR,
    RESP_DATA,
    ERR
  } state_t;

  state_t            state;
  logic              rd_pend;
  logic              is_write;
  logic [BW-1:0]     bcnt;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  logic collecting;
  logic pushing;
  logic timeout_hit;

  // A pop is only issued when the previous popped byte has already been
  // captured, so at most one byte is ever in flight and nothing beyond the
  // current frame is consumed.
  assign collecting = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign pushing    = (state == RESP_HDR) || (state == RESP_DATA) || (state == ERR);
  assign rx_rd_en   = collecting && !rx_empty && !rd_pend;
  assign tx_wr_en   = pushing && !tx_full;

  assign req_valid  = (state == REQ);
  assign req_we     = is_write;
  assign req_addr   = addr;
  assign req_wdata  = wdata;
  assign busy       = (state != IDLE);

  // An idle cycle is one with no byte in flight and none available; the
  // abort fires on the TIMEOUT-th consecutive idle cycle. Because rx_empty
  // is part of the condition, no pop can coincide with the abort.
  assign timeout_hit = (TIMEOUT != 0) && !rd_pend && rx_empty && (tcnt == TO_LAST);

  // Response byte currently offered to the transmit FIFO.
  always_comb begin
    tx_din = 8'h00;
    case (state)
      RESP_HDR:  tx_din = is_write ? 8'h81 : 8'h82;
      RESP_DATA: tx_din = 8'(rdata >> {bcnt, 3'b000});
      ERR:       tx_din = 8'hEE;
      default:   tx_din = 8'h00;
    endcase
  end

  // Frame decoder, bus sequencer and response generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_pend  <= 1'b0;
      is_write <= 1'b0;
      bcnt     <= '0;
      tcnt     <= '0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      err_cnt  <= 8'h00;
    end else begin
      rd_pend <= rx_rd_en;
      case (state)
        IDLE: begin
          if (rd_pend) begin
            if (rx_dout == 8'h01 || rx_dout == 8'h02) begin
              is_write <= (rx_dout == 8'h01);
              bcnt     <= '0;
              tcnt     <= '0;
              state    <= ADDR;
            end else begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
              state <= ERR;
            end
          end
        end
        ADDR: begin
          if (rd_pend) begin
            addr[8*bcnt +: 8] <= rx_dout;
            tcnt <= '0;
            if (bcnt == ADDR_LAST) begin
              bcnt  <= '0;
              state <= is_write ? DATA : REQ;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (timeout_hit) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            bcnt  <= '0;
            tcnt  <= '0;
            state <= IDLE;
          end else if (rx_empty && TIMEOUT != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DATA: begin
          if (rd_pend) begin
            wdata[8*bcnt +: 8] <= rx_dout;
            tcnt <= '0;
            if (bcnt == DATA_LAST) begin
              bcnt  <= '0;
              state <= REQ;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (timeout_hit) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            bcnt  <= '0;
            tcnt  <= '0;
            state <= IDLE;
          end else if (rx_empty && TIMEOUT != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        REQ: begin
          if (req_ready) state <= WAIT;
        end
        // Entered on the acceptance edge, so a response pulse coincident
        // with acceptance was seen in REQ and is ignored.
        WAIT: begin
          if (rsp_valid) begin
            rdata <= rsp_rdata;
            state <= RESP_HDR;
          end
        end
        RESP_HDR: begin
          if (!tx_full) begin
            bcnt  <= '0;
            state <= is_write ? IDLE : RESP_DATA;
          end
        end
        RESP_DATA: begin
          if (!tx_full) begin
            if (bcnt == DATA_LAST) begin
              bcnt  <= '0;
              state <= IDLE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ERR: begin
          if (!tx_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_cmd_engine.sv
// tb_usb_cmd_engine
//   Directed bench for usb_cmd_engine (TIMEOUT = 16). Models the receive FIFO,
//   transmit FIFO and bus target around the engine, logs every pushed byte
//   and accepted request, and compares them with hand-computed frames.
module tb_usb_cmd_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_empty;
  logic        rx_rd_en;
  logic [7:0]  rx_dout;
  logic        tx_full;
  logic        tx_wr_en;
  logic [7:0]  tx_din;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_cnt;
  logic        busy;

  always #5 clk = ~clk;

  usb_cmd_engine #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_empty (rx_empty),
    .rx_rd_en (rx_rd_en),
    .rx_dout  (rx_dout),
    .tx_full  (tx_full),
    .tx_wr_en (tx_wr_en),
    .tx_din   (tx_din),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic        req_we_log[$];
  logic [31:0] req_addr_log[$];
  logic [31:0] req_wdata_log[$];

  bit          pop_pend = 1'b0;
  int          stab_err = 0;
  int          full_wr_err = 0;
  int          req_hi = 0;
  int          ready_delay = 0;
  int          rdy_cnt = 0;
  int          rsp_delay = 2;
  int          rsp_cnt = 0;
  int          full_at = -1;
  int          full_left = 0;
  logic [31:0] rsp_data = 32'h0;
  bit          in_req = 1'b0;
  logic        held_we;
  logic [31:0] held_addr;
  logic [31:0] held_wdata;

  // Mid-cycle observer: DUT outputs are stable here, and anything seen with
  // its strobe high takes effect at the coming rising edge.
  always @(negedge clk) begin
    pop_pend = rx_rd_en;
    if (tx_wr_en) tx_log.push_back(tx_din);
    if (tx_wr_en && tx_full) full_wr_err++;
    if (req_valid) begin
      req_hi++;
      if (!in_req) begin
        in_req     = 1'b1;
        held_we    = req_we;
        held_addr  = req_addr;
        held_wdata = req_wdata;
      end else if (req_we !== held_we || req_addr !== held_addr || req_wdata !== held_wdata) begin
        stab_err++;
      end
      if (req_ready) begin
        req_we_log.push_back(req_we);
        req_addr_log.push_back(req_addr);
        req_wdata_log.push_back(req_wdata);
        in_req  = 1'b0;
        rsp_cnt = rsp_delay;
      end
    end else begin
      in_req = 1'b0;
    end
  end

  // Environment driver, 1 time unit after each rising edge: FIFO data and
  // flags, bus ready with a configurable stall, and the delayed response.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      if (rx_q.size() > 0) rx_dout = rx_q.pop_front();
      pop_pend = 1'b0;
    end
    rx_empty  = (rx_q.size() == 0);
    rsp_rdata = rsp_data;
    rsp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) rsp_valid = 1'b1;
    end
    if (req_valid) begin
      req_ready = (rdy_cnt >= ready_delay);
      rdy_cnt++;
    end else begin
      req_ready = 1'b0;
      rdy_cnt   = 0;
    end
    tx_full = 1'b0;
    if (full_at >= 0 && tx_log.size() == full_at && full_left > 0) begin
      tx_full = 1'b1;
      full_left--;
    end
  end

  // Transmitted bytes packed first-byte-most-significant for compact compares.
  function automatic logic [63:0] tx_packed();
    logic [63:0] v = '0;
    foreach (tx_log[i]) v = {v[55:0], tx_log[i]};
    return v;
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    req_we_log.delete();
    req_addr_log.delete();
    req_wdata_log.delete();
    stab_err    = 0;
    full_wr_err = 0;
    req_hi      = 0;
  endtask

  // Waits for the frame to drain and the engine to go idle; ok = 0 on budget expiry.
  task automatic wait_done(input int exp_tx, output bit ok);
    int n = 0;
    while (n < 400 && !(rx_q.size() == 0 && tx_log.size() >= exp_tx && !busy && !pop_pend)) begin
      @(posedge clk);
      #2;
      n++;
    end
    ok = (n < 400);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [84:0] snap;
    rst_n = 1'b0;
    #3;
    snap = {rx_rd_en, tx_wr_en, tx_din, req_valid, req_we, req_addr, req_wdata, err_cnt, busy};
    checks++;
    if (snap !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", snap);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || rx_rd_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b rx_rd_en=%b, want 0 0", busy, rx_rd_en);
    end
  endtask

  task automatic test_write();
    logic [7:0] f[9] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bit ok;
    clear_logs();
    ready_delay = 0;
    rsp_delay   = 2;
    foreach (f[i]) rx_q.push_back(f[i]);
    wait_done(1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL write_done: timed out, tx=%0d", tx_log.size()); end
    checks++;
    if (req_addr_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL write_req_count: got %0d, want 1", req_addr_log.size());
    end else begin
      checks++;
      if (req_we_log[0] !== 1'b1 || req_addr_log[0] !== 32'h80000010 || req_wdata_log[0] !== 32'hDEADBEEF) begin
        errors++;
        $display("[TB] FAIL write_req: we=%b addr=%h wdata=%h, want 1 80000010 deadbeef",
                 req_we_log[0], req_addr_log[0], req_wdata_log[0]);
      end
    end
    checks++;
    if (tx_log.size() != 1 || tx_packed() !== 64'h81) begin
      errors++;
      $display("[TB] FAIL write_tx: n=%0d bytes=%h, want 1 81", tx_log.size(), tx_packed());
    end
  endtask

  task automatic test_read();
    logic [7:0] f[5] = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h80};
    bit ok;
    clear_logs();
    ready_delay = 3;
    rsp_delay   = 2;
    rsp_data    = 32'h12345678;
    foreach (f[i]) rx_q.push_back(f[i]);
    wait_done(5, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL read_done: timed out, tx=%0d", tx_log.size()); end
    checks++;
    if (req_addr_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL read_req_count: got %0d, want 1", req_addr_log.size());
    end else begin
      checks++;
      if (req_we_log[0] !== 1'b0 || req_addr_log[0] !== 32'h80000004) begin
        errors++;
        $display("[TB] FAIL read_req: we=%b addr=%h, want 0 80000004", req_we_log[0], req_addr_log[0]);
      end
    end
    // Three stall cycles plus the accepting cycle.
    checks++;
    if (req_hi != 4 || stab_err != 0) begin
      errors++;
      $display("[TB] FAIL read_req_hold: valid_cycles=%0d unstable=%0d, want 4 0", req_hi, stab_err);
    end
    checks++;
    if (tx_log.size() != 5 || tx_packed() !== 64'h82_78_56_34_12) begin
      errors++;
      $display("[TB] FAIL read_tx: n=%0d bytes=%h, want 5 8278563412", tx_log.size(), tx_packed());
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] f[10] = '{8'h7F, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bit ok;
    clear_logs();
    ready_delay = 0;
    rsp_delay   = 2;
    foreach (f[i]) rx_q.push_back(f[i]);
    wait_done(2, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL badop_done: timed out, tx=%0d", tx_log.size()); end
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL badop_err_cnt: got %0d, want 1", err_cnt);
    end
    checks++;
    if (tx_log.size() != 2 || tx_packed() !== 64'hEE81) begin
      errors++;
      $display("[TB] FAIL badop_tx: n=%0d bytes=%h, want 2 ee81", tx_log.size(), tx_packed());
    end
    checks++;
    if (req_addr_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL badop_req_count: got %0d, want 1", req_addr_log.size());
    end else begin
      checks++;
      if (req_we_log[0] !== 1'b1 || req_addr_log[0] !== 32'h0 || req_wdata_log[0] !== 32'hDDCCBBAA) begin
        errors++;
        $display("[TB] FAIL badop_req: we=%b addr=%h wdata=%h, want 1 00000000 ddccbbaa",
                 req_we_log[0], req_addr_log[0], req_wdata_log[0]);
      end
    end
  endtask

  task automatic test_tx_backpressure();
    logic [7:0] f[5] = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h80};
    bit ok;
    clear_logs();
    ready_delay = 0;
    rsp_delay   = 2;
    rsp_data    = 32'h12345678;
    full_at     = 2;
    full_left   = 5;
    foreach (f[i]) rx_q.push_back(f[i]);
    wait_done(5, ok);
    full_at = -1;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_done: timed out, tx=%0d", tx_log.size()); end
    checks++;
    if (tx_log.size() != 5 || tx_packed() !== 64'h82_78_56_34_12) begin
      errors++;
      $display("[TB] FAIL bp_tx: n=%0d bytes=%h, want 5 8278563412", tx_log.size(), tx_packed());
    end
    checks++;
    if (full_wr_err != 0) begin
      errors++;
      $display("[TB] FAIL bp_push_when_full: got %0d, want 0", full_wr_err);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] g[9] = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    int  guard = 0;
    int  n = 0;
    bit  ok;
    clear_logs();
    rx_q.push_back(8'h02);
    rx_q.push_back(8'h04);
    while (rx_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      #2;
      guard++;
    end
    // From the pop of 0x04: one edge captures it, then 16 idle edges end in the abort.
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 100);
    checks++;
    if (n != 17) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d, want 17", n);
    end
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (err_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL timeout_err_cnt: got %0d, want 2", err_cnt);
    end
    checks++;
    if (req_hi != 0 || tx_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout_side_effects: req_cycles=%0d tx=%0d, want 0 0", req_hi, tx_log.size());
    end
    foreach (g[i]) rx_q.push_back(g[i]);
    wait_done(1, ok);
    checks++;
    if (!ok || tx_log.size() != 1 || tx_packed() !== 64'h81) begin
      errors++;
      $display("[TB] FAIL timeout_next_tx: done=%b n=%0d bytes=%h, want 1 1 81", ok, tx_log.size(), tx_packed());
    end
    checks++;
    if (req_addr_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL timeout_next_count: got %0d, want 1", req_addr_log.size());
    end else begin
      checks++;
      if (req_addr_log[0] !== 32'h20 || req_wdata_log[0] !== 32'h11223344) begin
        errors++;
        $display("[TB] FAIL timeout_next_req: addr=%h wdata=%h, want 00000020 11223344",
                 req_addr_log[0], req_wdata_log[0]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] f[5] = '{8'h02, 8'h08, 8'h00, 8'h00, 8'h00};
    logic [84:0] snap;
    int guard = 0;
    clear_logs();
    ready_delay = 0;
    rsp_delay   = 30;
    foreach (f[i]) rx_q.push_back(f[i]);
    while (req_addr_log.size() == 0 && guard < 100) begin
      @(posedge clk);
      #2;
      guard++;
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || req_valid !== 1'b0 || err_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL wait_state: busy=%b req_valid=%b err_cnt=%0d, want 1 0 2", busy, req_valid, err_cnt);
    end
    rst_n = 1'b0;
    #1;
    snap = {rx_rd_en, tx_wr_en, tx_din, req_valid, req_we, req_addr, req_wdata, err_cnt, busy};
    checks++;
    if (snap !== '0) begin
      errors++;
      $display("[TB] FAIL wait_reset_outputs: got %h, want 0", snap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    checks++;
    if (tx_log.size() != 0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL late_rsp: tx=%0d busy=%b err_cnt=%0d, want 0 0 0", tx_log.size(), busy, err_cnt);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_empty  = 1'b1;
    rx_dout   = 8'h00;
    tx_full   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    $display("[TB] start");
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_tx_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/usb_cmd_engine.md
Name: usb_cmd_engine

Overview:
- Protocol stage directly behind the FT232H bridge.
- Consumes host bytes from the receive FIFO that the bridge fills, and decodes write/read command frames.
- Executes each frame as a single transaction on an internal SoC bus port.
- Pushes response bytes into the transmit FIFO that the bridge drains to the host.

Parameters:
- ADDR_W, 32, bus address width; multiple of 8; ADDR_BYTES = ADDR_W/8.
- DATA_W, 32, bus data width; multiple of 8; DATA_BYTES = DATA_W/8.
- TIMEOUT, 65535, maximum idle cycles between bytes of one frame before it is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_empty  in  1  receive FIFO empty.
- rx_rd_en  out  1  receive FIFO pop.
- rx_dout  in  8  receive FIFO data; valid the cycle after rx_rd_en is sampled high.
- tx_full  in  1  transmit FIFO full.
- tx_wr_en  out  1  transmit FIFO push.
- tx_din  out  8  transmit FIFO data.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts the request.
- req_we  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_W  bus address.
- req_wdata  out  DATA_W  write data.
- rsp_valid  in  1  bus response valid, one-cycle pulse.
- rsp_rdata  in  DATA_W  read data, valid with rsp_valid.
- err_cnt  out  8  count of aborted frames; saturates at 255.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, rd_pend 0, err_cnt 0, internal address/data/byte-count registers 0.

Frame format (multi-byte fields are little-endian, LSB first):
- Write: 0x01, ADDR_BYTES address bytes, DATA_BYTES data bytes. Response: one byte, 0x81.
- Read: 0x02, ADDR_BYTES address bytes. Response: 0x82 followed by DATA_BYTES read-data bytes.
- Any other opcode: response 0xEE; err_cnt increments; return to IDLE.

Receive pop rule:
- rx_rd_en = collecting state (IDLE, ADDR, DATA) & ~rx_empty & ~rd_pend.
- rd_pend is set the cycle after a pop; the byte is captured from rx_dout in that cycle, then rd_pend clears.
- Peak rate is therefore one byte per 2 cycles.
- The engine never pops beyond the end of the current frame.

States:
- IDLE: captured byte is the opcode. 0x01/0x02 -> ADDR with bcnt = 0. Any other value -> ERR.
- ADDR: shift byte into addr[8*bcnt +: 8]. On the last byte: write -> DATA (bcnt = 0); read -> REQ.
- DATA: shift byte into wdata likewise. Last byte -> REQ.
- REQ: req_valid = 1, with req_we/req_addr/req_wdata held stable until req_ready is seen high. Accepted -> WAIT.
- WAIT: on rsp_valid, latch rsp_rdata -> RESP_HDR. A rsp_valid in the same cycle as acceptance is ignored; the response must arrive at least one cycle later.
- RESP_HDR: push 0x81 or 0x82 when ~tx_full. Write -> IDLE; read -> RESP_DATA with bcnt = 0.
- RESP_DATA: push rdata byte bcnt on each cycle with ~tx_full. After the last byte -> IDLE.
- ERR: push 0xEE when ~tx_full -> IDLE.

Back-pressure and timing:
- tx_wr_en = 1 only if ~tx_full. tx_din is valid in the same cycle as tx_wr_en.
- tx_full stalls the current byte with no loss or duplication.

Timeout:
- Applies in ADDR and DATA only. The counter resets on every captured byte.
- When it reaches TIMEOUT with no byte: abort to IDLE, err_cnt++, no response byte, no bus request.

Latency and boundaries:
- Read latency is not bounded; there is no timeout in REQ or WAIT.
- A popped byte with rd_pend set in the timeout cycle is captured before the abort takes effect.
- Reset mid-frame or mid-bus-transaction returns to IDLE immediately and drops the frame. Any outstanding bus response after reset is ignored.
- Address and data byte counters never exceed ADDR_BYTES-1 / DATA_BYTES-1.

Test Plan:
- Write frame 01 10 00 00 80 EF BE AD DE, req_ready tied 1, rsp_valid 2 cycles after acceptance -> exactly one request with we=1, addr=0x80000010, wdata=0xDEADBEEF; tx receives exactly 81.
- Read frame 02 04 00 00 80, req_ready delayed 3 cycles, rsp_rdata=0x12345678 -> req_valid held stable through the stall, we=0, addr=0x80000004; tx receives 82 78 56 34 12.
- Opcode 0x7F followed by 01 00 00 00 00 AA BB CC DD -> tx receives EE, err_cnt=1; the following write frame executes normally with addr=0, wdata=0xDDCCBBAA.
- Same read as the read case with tx_full asserted for 5 cycles between byte 2 and byte 3 of the response -> bytes 82 78 56 34 12, no duplicates and no drops.
- TIMEOUT=16; send 02 04 then stall rx -> abort after 16 idle cycles, err_cnt=1, no req_valid, no tx bytes; the next full frame works.
- Assert rst_n low while in WAIT -> all outputs return to 0 and err_cnt=0; a late rsp_valid pulse produces no tx bytes.
